// File: rtl/fft_ctrl_pkg.sv
// Shared definitions for the FFT frame scheduler: FSM state encoding,
// default engine geometry and a helper for channel-index widths.
package fft_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    LOAD        = 3'd1,
    PAD         = 3'd2,
    WAIT_RESULT = 3'd3,
    DRAIN       = 3'd4
  } state_e;

  localparam int NUM_CH_DEF     = 4;
  localparam int FFT_SIZE_DEF   = 1024;
  localparam int DATA_WIDTH_DEF = 24;
  localparam int FFT_INDEX_W    = 11;

  // Width of a channel index; never below one bit.
  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int CH_W = ch_width(NUM_CH_DEF);

endpackage

// File: rtl/fft_frame_scheduler_if.sv
// Channel-side and engine-side signals of the FFT frame scheduler.
//   ch_req/ch_valid/ch_real/ch_imag : per-channel requests and samples (ch 0 in LSBs)
//   ch_ready/ch_grant               : one-hot handshake back to the channels
//   fft_real_in/fft_imag_in/fft_data_valid : sample stream into the engine
//   fft_valid/fft_index             : engine output burst observation
// master = scheduler, slave = channels + engine.
interface fft_frame_scheduler_if #(
  parameter int NUM_CH     = 4,
  parameter int DATA_WIDTH = 24
);
  import fft_ctrl_pkg::*;

  logic [NUM_CH-1:0]            ch_req;
  logic [NUM_CH-1:0]            ch_valid;
  logic [NUM_CH*DATA_WIDTH-1:0] ch_real;
  logic [NUM_CH*DATA_WIDTH-1:0] ch_imag;
  logic [NUM_CH-1:0]            ch_ready;
  logic [NUM_CH-1:0]            ch_grant;
  logic [DATA_WIDTH-1:0]        fft_real_in;
  logic [DATA_WIDTH-1:0]        fft_imag_in;
  logic                         fft_data_valid;
  logic                         fft_valid;
  logic [FFT_INDEX_W-1:0]       fft_index;

  modport master (
    input  ch_req, ch_valid, ch_real, ch_imag, fft_valid, fft_index,
    output ch_ready, ch_grant, fft_real_in, fft_imag_in, fft_data_valid
  );

  modport slave (
    output ch_req, ch_valid, ch_real, ch_imag, fft_valid, fft_index,
    input  ch_ready, ch_grant, fft_real_in, fft_imag_in, fft_data_valid
  );
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter. Search starts at ptr_q; the pointer moves to the
// channel after the winner only when 'advance' is high.
//   req       : request vector
//   advance   : commit the current winner and rotate priority
//   grant     : one-hot winner (combinational)
//   grant_idx : index of the winner
module rr_arbiter
  import fft_ctrl_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = ch_width(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic             advance,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx
);
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W:0]   idx;
  logic             found;

  // NOTE: every variable gets a default before any branch so no path leaves
  // it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = '0;
    for (int i = 0; i < N; i++) begin
      idx = {1'b0, ptr_q} + (IDX_W+1)'(i);
      if (idx >= (IDX_W+1)'(N)) idx = idx - (IDX_W+1)'(N);
      if (!found && req[idx[IDX_W-1:0]]) begin
        found                   = 1'b1;
        grant[idx[IDX_W-1:0]]   = 1'b1;
        grant_idx               = idx[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance && found) begin
      ptr_d = (grant_idx == IDX_W'(N-1)) ? '0 : grant_idx + IDX_W'(1);
    end
  end

  // NOTE: non-blocking assignment for state so every flop samples the
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end
endmodule

// File: rtl/fft_frame_scheduler.sv
// Time-shares one FFT engine among NUM_CH sources. Grants one channel per
// frame round-robin, muxes FFT_SIZE samples (zero-padding after a stall),
// then watches the engine output burst and reports completion/errors.
//   clk, rst    : clock, synchronous active-high reset
//   bus         : channel + engine signals (master modport)
//   out_channel : owner of the current/last frame
//   frame_done, err_stall, err_result : one-cycle pulses
//   busy        : not IDLE
//   frames_done : completed-frame counter (wraps)
module fft_frame_scheduler
  import fft_ctrl_pkg::*;
#(
  parameter int NUM_CH         = NUM_CH_DEF,
  parameter int FFT_SIZE       = FFT_SIZE_DEF,
  parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int STALL_TIMEOUT  = 64,
  parameter int RESULT_TIMEOUT = 8192
) (
  input  logic                        clk,
  input  logic                        rst,
  fft_frame_scheduler_if.master       bus,
  output logic [ch_width(NUM_CH)-1:0] out_channel,
  output logic                        frame_done,
  output logic                        err_stall,
  output logic                        err_result,
  output logic                        busy,
  output logic [15:0]                 frames_done
);
  localparam int CW      = ch_width(NUM_CH);
  localparam int CNT_W   = $clog2(FFT_SIZE);
  localparam int TMR_MAX = (RESULT_TIMEOUT > STALL_TIMEOUT) ? RESULT_TIMEOUT : STALL_TIMEOUT;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  state_e                state_q, state_d;
  logic [NUM_CH-1:0]     grant_q, grant_d;
  logic [CW-1:0]         chan_q, chan_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  // One timer serves both the LOAD stall watch and the result timeout.
  logic [TMR_W-1:0]      tmr_q, tmr_d;
  logic [DATA_WIDTH-1:0] re_q, re_d, im_q, im_d;
  logic                  dv_q, dv_d;
  logic                  frame_done_q, frame_done_d;
  logic                  err_stall_q, err_stall_d;
  logic                  err_result_q, err_result_d;
  logic [15:0]           frames_done_q, frames_done_d;

  logic [NUM_CH-1:0]     arb_grant;
  logic [CW-1:0]         arb_idx;
  logic                  advance;
  logic [NUM_CH-1:0]     ready;
  logic                  accept;

  rr_arbiter #(.N(NUM_CH), .IDX_W(CW)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (bus.ch_req),
    .advance   (advance),
    .grant     (arb_grant),
    .grant_idx (arb_idx)
  );

  assign ready  = (state_q == LOAD) ? grant_q : '0;
  assign accept = |(bus.ch_valid & ready);

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    chan_d        = chan_q;
    cnt_d         = cnt_q;
    tmr_d         = tmr_q;
    re_d          = '0;
    im_d          = '0;
    dv_d          = 1'b0;
    frame_done_d  = 1'b0;
    err_stall_d   = 1'b0;
    err_result_d  = 1'b0;
    frames_done_d = frames_done_q;
    advance       = 1'b0;

    unique case (state_q)
      IDLE: if (|bus.ch_req) begin
        advance = 1'b1;
        grant_d = arb_grant;
        chan_d  = arb_idx;
        cnt_d   = '0;
        tmr_d   = '0;
        state_d = LOAD;
      end
      LOAD: begin
        if (accept) begin
          re_d  = bus.ch_real[int'(chan_q)*DATA_WIDTH +: DATA_WIDTH];
          im_d  = bus.ch_imag[int'(chan_q)*DATA_WIDTH +: DATA_WIDTH];
          dv_d  = 1'b1;
          cnt_d = cnt_q + CNT_W'(1);
          tmr_d = '0;
          if (cnt_q == CNT_W'(FFT_SIZE-1)) state_d = WAIT_RESULT;
        end else if (tmr_q == TMR_W'(STALL_TIMEOUT-1)) begin
          err_stall_d = 1'b1;
          tmr_d       = '0;
          state_d     = PAD;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      PAD: begin
        dv_d  = 1'b1;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(FFT_SIZE-1)) state_d = WAIT_RESULT;
      end
      WAIT_RESULT: begin
        if (bus.fft_valid) begin
          state_d = DRAIN;
        end else if (tmr_q == TMR_W'(RESULT_TIMEOUT-1)) begin
          err_result_d = 1'b1;
          grant_d      = '0;
          state_d      = IDLE;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      DRAIN: if (bus.fft_valid && bus.fft_index == FFT_INDEX_W'(FFT_SIZE-1)) begin
        frame_done_d  = 1'b1;
        frames_done_d = frames_done_q + 16'd1;
        grant_d       = '0;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Engine output outside a result window is flagged but otherwise ignored.
    if (bus.fft_valid && (state_q == IDLE || state_q == LOAD || state_q == PAD)) begin
      err_result_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      chan_q        <= '0;
      cnt_q         <= '0;
      tmr_q         <= '0;
      re_q          <= '0;
      im_q          <= '0;
      dv_q          <= 1'b0;
      frame_done_q  <= 1'b0;
      err_stall_q   <= 1'b0;
      err_result_q  <= 1'b0;
      frames_done_q <= '0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      chan_q        <= chan_d;
      cnt_q         <= cnt_d;
      tmr_q         <= tmr_d;
      re_q          <= re_d;
      im_q          <= im_d;
      dv_q          <= dv_d;
      frame_done_q  <= frame_done_d;
      err_stall_q   <= err_stall_d;
      err_result_q  <= err_result_d;
      frames_done_q <= frames_done_d;
    end
  end

  assign bus.ch_ready       = ready;
  assign bus.ch_grant       = grant_q;
  assign bus.fft_real_in    = re_q;
  assign bus.fft_imag_in    = im_q;
  assign bus.fft_data_valid = dv_q;
  assign out_channel        = chan_q;
  assign frame_done         = frame_done_q;
  assign err_stall          = err_stall_q;
  assign err_result         = err_result_q;
  assign busy               = (state_q != IDLE);
  assign frames_done        = frames_done_q;
endmodule

// File: tb/tb_fft_frame_scheduler.sv
// Directed bench for fft_frame_scheduler: reset, stray engine output,
// single frame, round-robin fairness, stall padding, result timeout,
// reset mid-LOAD and frame-counter wrap.
module tb_fft_frame_scheduler;
  import fft_ctrl_pkg::*;

  localparam int NCH = 4;
  localparam int DW  = 24;
  localparam int N   = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  out_channel;
  logic        frame_done, err_stall, err_result, busy;
  logic [15:0] frames_done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fft_frame_scheduler_if #(.NUM_CH(NCH), .DATA_WIDTH(DW)) bus ();

  fft_frame_scheduler #(
    .NUM_CH(NCH), .FFT_SIZE(N), .DATA_WIDTH(DW),
    .STALL_TIMEOUT(64), .RESULT_TIMEOUT(8192)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .out_channel (out_channel),
    .frame_done  (frame_done),
    .err_stall   (err_stall),
    .err_result  (err_result),
    .busy        (busy),
    .frames_done (frames_done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Distinct per-channel sample values so the mux selection is visible.
  function automatic logic [DW-1:0] s_re(input int c, input int k);
    return DW'(c * 'h100000 + k);
  endfunction

  function automatic logic [DW-1:0] s_im(input int c, input int k);
    return DW'(24'hFFFFFF) - s_re(c, k);
  endfunction

  task automatic present(input int k);
    for (int c = 0; c < NCH; c++) begin
      bus.ch_real[c*DW +: DW] = s_re(c, k);
      bus.ch_imag[c*DW +: DW] = s_im(c, k);
    end
  endtask

  task automatic load_frame(input int ch, input int n, input bit chk);
    for (int k = 0; k < n; k++) begin
      present(k);
      bus.ch_valid     = '0;
      bus.ch_valid[ch] = 1'b1;
      tick();
      if (chk) begin
        check("ld_dv",   32'(bus.fft_data_valid), 32'd1);
        check("ld_real", 32'(bus.fft_real_in), 32'(s_re(ch, k)));
        check("ld_imag", 32'(bus.fft_imag_in), 32'(s_im(ch, k)));
      end
    end
    bus.ch_valid = '0;
  endtask

  task automatic wait_grant(input logic [NCH-1:0] exp, input string tag, output int waited);
    waited = 0;
    while (bus.ch_grant == '0 && waited < 20) begin
      tick();
      waited++;
    end
    check({tag, "_grant"}, 32'(bus.ch_grant), 32'(exp));
    check({tag, "_ready"}, 32'(bus.ch_ready), 32'(exp));
  endtask

  // Engine stub: bins 0..N-1 back to back, then one idle cycle.
  task automatic burst(input int exp_ch, input string tag);
    int pulses;
    int done_bin;
    pulses   = 0;
    done_bin = -1;
    for (int b = 0; b < N; b++) begin
      bus.fft_valid = 1'b1;
      bus.fft_index = 11'(b);
      tick();
      if (b == 0) begin
        check({tag, "_dv_off"}, 32'(bus.fft_data_valid), 32'd0);
        check({tag, "_chan"}, 32'(out_channel), 32'(exp_ch));
      end
      if (frame_done) begin
        pulses++;
        done_bin = b;
      end
    end
    bus.fft_valid = 1'b0;
    bus.fft_index = '0;
    tick();
    if (frame_done) pulses++;
    check({tag, "_done_cnt"}, 32'(pulses), 32'd1);
    check({tag, "_done_bin"}, 32'(done_bin), 32'(N-1));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int waited, cycles, zeros, nonzero;

    rst = 1'b1;
    bus.ch_req = '0; bus.ch_valid = '0; bus.ch_real = '0; bus.ch_imag = '0;
    bus.fft_valid = 1'b0; bus.fft_index = '0;
    repeat (3) tick();

    // Reset state
    check("rst_grant", 32'(bus.ch_grant), 32'd0);
    check("rst_ready", 32'(bus.ch_ready), 32'd0);
    check("rst_dv", 32'(bus.fft_data_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_frames", 32'(frames_done), 32'd0);
    check("rst_chan", 32'(out_channel), 32'd0);
    check("rst_errs", 32'({frame_done, err_stall, err_result}), 32'd0);
    rst = 1'b0;
    tick();

    // Stray engine output in IDLE
    bus.fft_valid = 1'b1;
    tick();
    check("stray_err", 32'(err_result), 32'd1);
    check("stray_busy", 32'(busy), 32'd0);
    bus.fft_valid = 1'b0;
    tick();
    check("stray_pulse", 32'(err_result), 32'd0);

    // Single channel frame; request dropped after grant
    bus.ch_req = 4'b0001;
    tick();
    check("t1_grant", 32'(bus.ch_grant), 32'd1);
    check("t1_ready", 32'(bus.ch_ready), 32'd1);
    check("t1_busy", 32'(busy), 32'd1);
    bus.ch_req = '0;
    load_frame(0, N, 1'b1);
    check("t1_ready_off", 32'(bus.ch_ready), 32'd0);
    burst(0, "t1");
    check("t1_frames", 32'(frames_done), 32'd1);
    check("t1_idle", 32'(busy), 32'd0);
    check("t1_grant_off", 32'(bus.ch_grant), 32'd0);

    // Fairness: all channels requesting for 8 frames
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.ch_req = 4'b1111;
    for (int f = 0; f < 8; f++) begin
      wait_grant(4'(1 << (f % 4)), "t2", waited);
      if (f > 0) check("t2_b2b", 32'(waited), 32'd0);
      if (f == 7) bus.ch_req = '0;
      load_frame(f % 4, N, 1'b0);
      burst(f % 4, "t2");
    end
    check("t2_frames", 32'(frames_done), 32'd8);
    check("t2_idle", 32'(busy), 32'd0);

    // Stall on channel 2 after 500 samples
    bus.ch_req = 4'b0100;
    wait_grant(4'b0100, "t3", waited);
    bus.ch_req = '0;
    load_frame(2, 500, 1'b1);
    cycles = 0;
    while (!err_stall && cycles < 200) begin
      tick();
      cycles++;
    end
    check("t3_stall_lat", 32'(cycles), 32'd64);
    check("t3_pad_ready", 32'(bus.ch_ready), 32'd0);
    zeros = 0;
    nonzero = 0;
    for (int i = 0; i < 530; i++) begin
      tick();
      if (i == 0) check("t3_stall_pulse", 32'(err_stall), 32'd0);
      if (bus.fft_data_valid) begin
        if (bus.fft_real_in == '0 && bus.fft_imag_in == '0) zeros++;
        else nonzero++;
      end
    end
    check("t3_zeros", 32'(zeros), 32'd524);
    check("t3_nonzero", 32'(nonzero), 32'd0);
    burst(2, "t3");
    check("t3_frames", 32'(frames_done), 32'd9);

    // Result timeout on channel 0, then next grant goes to channel 1
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.ch_req = 4'b0001;
    tick();
    check("t4_grant", 32'(bus.ch_grant), 32'd1);
    bus.ch_req = '0;
    load_frame(0, N, 1'b0);
    cycles = 0;
    while (!err_result && cycles < 9000) begin
      tick();
      cycles++;
    end
    check("t4_timeout", 32'(cycles), 32'd8192);
    check("t4_busy", 32'(busy), 32'd0);
    check("t4_grant_off", 32'(bus.ch_grant), 32'd0);
    tick();
    check("t4_pulse", 32'(err_result), 32'd0);
    bus.ch_req = 4'b1111;
    wait_grant(4'b0010, "t4_next", waited);

    // Reset in the middle of channel 1's LOAD
    load_frame(1, 300, 1'b0);
    present(300);
    bus.ch_valid[1] = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.ch_valid = '0;
    check("t5_grant", 32'(bus.ch_grant), 32'd0);
    check("t5_ready", 32'(bus.ch_ready), 32'd0);
    check("t5_dv", 32'(bus.fft_data_valid), 32'd0);
    check("t5_real", 32'(bus.fft_real_in), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_chan", 32'(out_channel), 32'd0);
    check("t5_errs", 32'({frame_done, err_stall, err_result}), 32'd0);
    wait_grant(4'b0001, "t5_regrant", waited);
    bus.ch_req = '0;

    // Frame counter wrap
    force dut.frames_done_q = 16'hFFFF;
    tick();
    release dut.frames_done_q;
    check("t6_preload", 32'(frames_done), 32'h0000FFFF);
    load_frame(0, N, 1'b0);
    burst(0, "t6");
    check("t6_wrap", 32'(frames_done), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fft_frame_scheduler.md
# fft_frame_scheduler

Time-shares the single 1024-point FFT engine between `NUM_CH` sample sources. The block sits between the per-channel front ends and the FFT engine's input port. It grants the engine to one channel per frame in round-robin order and muxes exactly `FFT_SIZE` samples into it. It then watches the engine's output burst, tags it with the owning channel and reports frame completion or protocol errors.

## Interface
Parameters:
- `NUM_CH`, 4: number of requesting channels (2..8)
- `FFT_SIZE`, 1024: samples per frame; must match the engine
- `DATA_WIDTH`, 24: sample width per I/Q component
- `STALL_TIMEOUT`, 64: idle cycles allowed in LOAD before zero-padding
- `RESULT_TIMEOUT`, 8192: cycles allowed from end of load to first `fft_valid`

Ports (all synchronous to `clk`; reset is synchronous and active-high):
- `clk`  in  1  single clock
- `rst`  in  1  synchronous active-high reset
- `ch_req`  in  NUM_CH  channel has a full frame to send
- `ch_real`, `ch_imag`  in  NUM_CH*DATA_WIDTH each  packed per-channel samples, channel 0 in the LSBs
- `ch_valid`  in  NUM_CH  per-channel sample valid
- `ch_ready`  out  NUM_CH  one-hot; asserted only for the granted channel in LOAD
- `ch_grant`  out  NUM_CH  one-hot owner of the engine, held LOAD through DRAIN
- `fft_real_in`, `fft_imag_in`  out  DATA_WIDTH each  sample to the engine
- `fft_data_valid`  out  1  sample strobe to the engine
- `fft_valid`  in  1  engine output valid
- `fft_index`  in  11  engine output bin index
- `out_channel`  out  clog2(NUM_CH)  owner of the current output burst
- `frame_done`  out  1  one-cycle pulse on the final output bin
- `err_stall`  out  1  one-cycle pulse when padding begins
- `err_result`  out  1  one-cycle pulse on result timeout or unexpected `fft_valid`
- `busy`  out  1  state is not IDLE
- `frames_done`  out  16  completed-frame count; wraps at 65535 → 0

## Operation
- States: IDLE, LOAD, PAD, WAIT_RESULT, DRAIN.
- **IDLE:** when any `ch_req` bit is set, choose a channel round-robin:
  - Search starts at the channel after the last grant.
  - Register the winner's one-hot in `ch_grant` and its index in `out_channel`.
  - Clear the sample counter and go to LOAD.
- **LOAD:**
  - `ch_ready` equals `ch_grant`.
  - A sample is accepted when `ch_valid[g] & ch_ready[g]`.
  - Each accepted sample is registered onto `fft_real_in`/`fft_imag_in` with `fft_data_valid`=1, and the counter increments.
  - Acceptance of sample `FFT_SIZE-1` → WAIT_RESULT.
  - `STALL_TIMEOUT` consecutive cycles with no accept → pulse `err_stall` and go to PAD.
- **PAD:**
  - Drive zero samples at one per cycle with `fft_data_valid`=1 until the counter reaches `FFT_SIZE-1`.
  - Then go to WAIT_RESULT.
  - `ch_ready`=0.
- **WAIT_RESULT:**
  - First `fft_valid` → DRAIN.
  - `RESULT_TIMEOUT` cycles with no `fft_valid` → pulse `err_result`, clear `ch_grant`, go to IDLE.
- **DRAIN:**
  - `fft_valid` with `fft_index==FFT_SIZE-1` → pulse `frame_done`, increment `frames_done`, clear `ch_grant`, go to IDLE.
  - A drop of `fft_valid` mid-burst is tolerated.
- `fft_valid` seen in IDLE, LOAD or PAD → pulse `err_result` and ignore it; state is unchanged.
- Dropping `ch_req` after a grant has no effect, because the frame is committed. Requests from other channels are held off until IDLE.
- The round-robin pointer advances only on a grant.

## Timing
- Reset values: all outputs 0, state IDLE, round-robin pointer set so channel 0 has priority, `frames_done`=0.
- Reset asserted mid-frame aborts everything within the same edge. There is no `frame_done` pulse; the engine is not flushed.
- Grant latency: `ch_req` sampled in IDLE → `ch_grant`/`ch_ready` high on the next cycle.
- Sample latency: accept at edge N → `fft_data_valid` high from edge N to N+1, i.e. 1 cycle.
- Minimum LOAD length is `FFT_SIZE` cycles.
- Back-to-back frames: IDLE lasts 1 cycle between DRAIN and the next LOAD.
- Each pulse output lasts exactly 1 cycle.

## Structure
- Shared package `fft_ctrl_pkg`:
  - state enum (IDLE=0, LOAD=1, PAD=2, WAIT_RESULT=3, DRAIN=4)
  - `CH_W` = clog2(`NUM_CH`)
  - default `FFT_SIZE`, `DATA_WIDTH`, `FFT_INDEX_W`=11
- One sub-module: `rr_arbiter`, a parameterised round-robin arbiter with one-hot output and an `advance` input.
- Sample mux, counters and FSM live in the top level.

## Test plan
- **Single channel:** `ch_req`=4'b0001 with 1024 contiguous samples 0..1023, then engine stub bursts bins 0..1023 → `fft_data_valid` carries 0..1023 one cycle delayed; `frame_done` pulses once at bin 1023; `frames_done`=1; `out_channel`=0.
- **Fairness:** all four `ch_req` bits held high for 8 frames → grant order 0,1,2,3,0,1,2,3; `frames_done`=8.
- **Stall:** channel 2 stops after 500 samples → `err_stall` pulses 64 cycles after the last accept; 524 zero samples follow; the frame then completes normally.
- **Result timeout:** the stub never asserts `fft_valid` → `err_result` pulses 8192 cycles after load end; `busy` drops; next grant goes to channel 1.
- **Reset mid-LOAD:** `rst` asserted at sample 300 → next cycle all outputs are 0 and state is IDLE; a fresh request re-grants channel 0.
- **Wrap:** preload `frames_done`=65535 by forcing, complete one frame → `frames_done`=0.
